// File: rtl/otter_branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// otter_branch_predictor_pkg
// Shared constants for the fetch-side branch predictor.
//   CTR_SNT/CTR_WNT/CTR_WT/CTR_ST : 2-bit saturating counter encodings
//   DEFAULT_ENTRIES               : default table depth
//   ctr_alloc()                   : counter value given to a freshly allocated entry
// -----------------------------------------------------------------------------
package otter_branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

  localparam int DEFAULT_ENTRIES = 16;

  // A new entry starts in the weak state on the side of its first outcome.
  function automatic logic [1:0] ctr_alloc(input logic taken);
    return taken ? CTR_WT : CTR_WNT;
  endfunction

endpackage

// File: rtl/otter_sat_ctr2.sv
// -----------------------------------------------------------------------------
// otter_sat_ctr2
// Combinational next-state of a 2-bit saturating counter.
// Ports:
//   ctr      in  2  current counter value
//   taken    in  1  resolved outcome (1 = count up, 0 = count down)
//   ctr_next out 2  next counter value, clamped to CTR_SNT..CTR_ST
// -----------------------------------------------------------------------------
module otter_sat_ctr2
  import otter_branch_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// otter_branch_predictor
// Direct-mapped branch history table (2-bit counters) plus branch target
// buffer. Lookup is combinational from the fetch PC; training happens on the
// rising clock edge from the execute-stage resolution.
//
// Optional feature macro: OTTER_BP_PERF_EN (adds update/mispredict counters).
//
// Ports:
//   i_clk               in  1   core clock
//   i_rst_n             in  1   asynchronous active-low reset
//   i_flush             in  1   invalidate every entry at the next edge
//   i_lookup_pc         in  32  fetch PC
//   o_pred_hit          out 1   valid entry with matching tag
//   o_pred_taken        out 1   predicted taken
//   o_pred_target       out 32  predicted target (0 unless predicted taken)
//   o_perf_updates      out 32  [OTTER_BP_PERF_EN] resolved branch count
//   o_perf_mispredicts  out 32  [OTTER_BP_PERF_EN] misprediction count
//   i_upd_valid         in  1   a conditional branch resolved this cycle
//   i_upd_pc            in  32  PC of the resolved branch
//   i_upd_taken         in  1   resolved outcome
//   i_upd_target        in  32  resolved taken target
//   i_upd_pred_taken    in  1   prediction originally made for this branch
// -----------------------------------------------------------------------------
module otter_branch_predictor
  import otter_branch_predictor_pkg::*;
#(
  parameter int ENTRIES = DEFAULT_ENTRIES
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic [31:0] i_lookup_pc,
  output logic        o_pred_hit,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
`ifdef OTTER_BP_PERF_EN
  output logic [31:0] o_perf_updates,
  output logic [31:0] o_perf_mispredicts,
`endif
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_taken,
  input  logic [31:0] i_upd_target,
  input  logic        i_upd_pred_taken
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  // Table state
  logic              valid_reg  [ENTRIES];
  logic [TAG_W-1:0]  tag_reg    [ENTRIES];
  logic [1:0]        ctr_reg    [ENTRIES];
  logic [31:0]       target_reg [ENTRIES];

  // Address split: word-aligned index, remaining upper bits as tag.
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic [IDX_W-1:0]  upd_idx;
  logic [TAG_W-1:0]  upd_tag;

  assign lk_idx  = i_lookup_pc[IDX_W+1:2];
  assign lk_tag  = i_lookup_pc[31:IDX_W+2];
  assign upd_idx = i_upd_pc[IDX_W+1:2];
  assign upd_tag = i_upd_pc[31:IDX_W+2];

  // ---------------------------------------------------------------------------
  // Lookup: reads current state only, so a same-cycle update to the same
  // index is not visible until the following cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    o_pred_hit    = valid_reg[lk_idx] && (tag_reg[lk_idx] == lk_tag);
    o_pred_taken  = o_pred_hit && ctr_reg[lk_idx][1];
    o_pred_target = o_pred_taken ? target_reg[lk_idx] : 32'd0;
  end

  // ---------------------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------------------
  logic       upd_hit;
  logic [1:0] upd_ctr_next;

  assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

  otter_sat_ctr2 u_sat_ctr (
    .ctr      (ctr_reg[upd_idx]),
    .taken    (i_upd_taken),
    .ctr_next (upd_ctr_next)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        ctr_reg[i]    <= CTR_WNT;
        target_reg[i] <= 32'd0;
      end
    end else if (i_flush) begin
      // Flush takes priority; any update presented this cycle is dropped.
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i] <= 1'b0;
        ctr_reg[i]   <= CTR_WNT;
      end
    end else if (i_upd_valid) begin
      if (upd_hit) begin
        ctr_reg[upd_idx] <= upd_ctr_next;
        if (i_upd_taken) target_reg[upd_idx] <= i_upd_target;
      end else begin
        valid_reg[upd_idx]  <= 1'b1;
        tag_reg[upd_idx]    <= upd_tag;
        ctr_reg[upd_idx]    <= ctr_alloc(i_upd_taken);
        target_reg[upd_idx] <= i_upd_taken ? i_upd_target : 32'd0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters (saturating, survive flush)
  // ---------------------------------------------------------------------------
`ifdef OTTER_BP_PERF_EN
  logic [31:0] perf_updates_reg;
  logic [31:0] perf_mispredicts_reg;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      perf_updates_reg     <= 32'd0;
      perf_mispredicts_reg <= 32'd0;
    end else if (i_upd_valid) begin
      if (perf_updates_reg != 32'hFFFF_FFFF)
        perf_updates_reg <= perf_updates_reg + 32'd1;
      if ((i_upd_pred_taken != i_upd_taken) && (perf_mispredicts_reg != 32'hFFFF_FFFF))
        perf_mispredicts_reg <= perf_mispredicts_reg + 32'd1;
    end
  end

  assign o_perf_updates     = perf_updates_reg;
  assign o_perf_mispredicts = perf_mispredicts_reg;

  // Byte-offset bits never select an entry.
  logic unused_bits;
  assign unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0]};
`else
  // Byte-offset bits never select an entry; the carried prediction only
  // feeds the performance counters.
  logic unused_bits;
  assign unused_bits = ^{i_lookup_pc[1:0], i_upd_pc[1:0], i_upd_pred_taken};
`endif

endmodule

// File: tb/tb_otter_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_otter_branch_predictor
// Table-driven self-checking bench for otter_branch_predictor. Each row is
// applied for one clock: its lookup is checked before the edge (pre-update
// state), its update is applied at the edge. Expected lookups are queued when
// a row is driven and popped when the outputs are sampled.
// -----------------------------------------------------------------------------
module tb_otter_branch_predictor;
  import otter_branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_flush;
  logic [31:0] i_lookup_pc;
  logic        o_pred_hit;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
`ifdef OTTER_BP_PERF_EN
  logic [31:0] o_perf_updates;
  logic [31:0] o_perf_mispredicts;
  int          model_upd;
  int          model_mis;
`endif
  logic        i_upd_valid;
  logic [31:0] i_upd_pc;
  logic        i_upd_taken;
  logic [31:0] i_upd_target;
  logic        i_upd_pred_taken;

  // Standalone counter unit
  logic [1:0]  sc_ctr;
  logic        sc_taken;
  logic [1:0]  sc_next;

  always #5 clk = ~clk;

  otter_branch_predictor #(.ENTRIES(16)) dut (
    .i_clk              (clk),
    .i_rst_n            (i_rst_n),
    .i_flush            (i_flush),
    .i_lookup_pc        (i_lookup_pc),
    .o_pred_hit         (o_pred_hit),
    .o_pred_taken       (o_pred_taken),
    .o_pred_target      (o_pred_target),
`ifdef OTTER_BP_PERF_EN
    .o_perf_updates     (o_perf_updates),
    .o_perf_mispredicts (o_perf_mispredicts),
`endif
    .i_upd_valid        (i_upd_valid),
    .i_upd_pc           (i_upd_pc),
    .i_upd_taken        (i_upd_taken),
    .i_upd_target       (i_upd_target),
    .i_upd_pred_taken   (i_upd_pred_taken)
  );

  otter_sat_ctr2 u_sat (
    .ctr      (sc_ctr),
    .taken    (sc_taken),
    .ctr_next (sc_next)
  );

  typedef struct {
    string       name;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upred;
    logic        fl;
    logic [31:0] lk;
    logic        eh;
    logic        et;
    logic [31:0] etgt;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic vec_t mk(input string name, input logic uv, input logic [31:0] upc,
                              input logic ut, input logic [31:0] utgt, input logic fl,
                              input logic [31:0] lk, input logic eh, input logic et,
                              input logic [31:0] etgt);
    vec_t v;
    v.name = name; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt; v.upred = ut;
    v.fl = fl; v.lk = lk; v.eh = eh; v.et = et; v.etgt = etgt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_upd_valid      = v.uv;
    i_upd_pc         = v.upc;
    i_upd_taken      = v.ut;
    i_upd_target     = v.utgt;
    i_upd_pred_taken = v.upred;
    i_flush          = v.fl;
    i_lookup_pc      = v.lk;
    exp_q.push_back(v);
`ifdef OTTER_BP_PERF_EN
    if (v.uv) begin
      model_upd++;
      if (v.upred != v.ut) model_mis++;
    end
`endif
  endtask

  task automatic compare_out();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty actual=0 required=1");
    end else begin
      e = exp_q.pop_front();
      $display("txn %-14s upd=%0d pc=%08h t=%0d fl=%0d lk=%08h -> hit=%0d taken=%0d tgt=%08h",
               e.name, e.uv, e.upc, e.ut, e.fl, e.lk, o_pred_hit, o_pred_taken, o_pred_target);
      chk({e.name, "_hit"},    {31'd0, o_pred_hit},   {31'd0, e.eh});
      chk({e.name, "_taken"},  {31'd0, o_pred_taken}, {31'd0, e.et});
      chk({e.name, "_target"}, o_pred_target,         e.etgt);
    end
  endtask

  // Row applied for exactly one clock edge; outputs sampled on the negedge.
  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    drive(v);
    @(negedge clk);
    compare_out();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] inc_tbl [4];
    logic [1:0] dec_tbl [4];
    vec_t v;
    inc_tbl = '{2'd1, 2'd2, 2'd3, 2'd3};
    dec_tbl = '{2'd0, 2'd0, 2'd1, 2'd2};

`ifdef OTTER_BP_PERF_EN
    model_upd = 0;
    model_mis = 0;
`endif
    i_rst_n = 1'b0; i_flush = 1'b0; i_lookup_pc = 32'h100;
    i_upd_valid = 1'b0; i_upd_pc = 32'd0; i_upd_taken = 1'b0;
    i_upd_target = 32'd0; i_upd_pred_taken = 1'b0;
    sc_ctr = 2'd0; sc_taken = 1'b0;

    // Saturating counter unit: all 8 input combinations.
    for (int c = 0; c < 4; c++) begin
      for (int t = 0; t < 2; t++) begin
        sc_ctr   = c[1:0];
        sc_taken = t[0];
        #1;
        chk($sformatf("satctr_c%0d_t%0d", c, t), {30'd0, sc_next},
            {30'd0, (t == 1) ? inc_tbl[c] : dec_tbl[c]});
      end
    end

    // Outputs while held in reset.
    #2;
    chk("rst_hit",    {31'd0, o_pred_hit},   32'd0);
    chk("rst_taken",  {31'd0, o_pred_taken}, 32'd0);
    chk("rst_target", o_pred_target,         32'd0);
`ifdef OTTER_BP_PERF_EN
    chk("rst_perf_upd", o_perf_updates,     32'd0);
    chk("rst_perf_mis", o_perf_mispredicts, 32'd0);
`endif
    @(posedge clk); #1; i_rst_n = 1'b1;

    // name, uv, upc, ut, utgt, fl, lookup, exp hit, exp taken, exp target
    // 0x100/0x200/0x300/0x500 share index 0 with ENTRIES=16.
    vecs.push_back(mk("reset_lk",   0, 32'h0,   0, 32'h0,    0, 32'h100, 0, 0, 32'h0));
    vecs.push_back(mk("alloc_t",    1, 32'h100, 1, 32'h80,   0, 32'h100, 0, 0, 32'h0));
    vecs.push_back(mk("after_alloc",0, 32'h0,   0, 32'h0,    0, 32'h100, 1, 1, 32'h80));
    vecs.push_back(mk("nt1",        1, 32'h100, 0, 32'h0,    0, 32'h100, 1, 1, 32'h80));
    vecs.push_back(mk("nt2",        1, 32'h100, 0, 32'h0,    0, 32'h100, 1, 0, 32'h0));
    vecs.push_back(mk("ctr00",      0, 32'h0,   0, 32'h0,    0, 32'h100, 1, 0, 32'h0));
    vecs.push_back(mk("sat_t1",     1, 32'h200, 1, 32'h240,  0, 32'h100, 1, 0, 32'h0));
    vecs.push_back(mk("sat_t2",     1, 32'h200, 1, 32'h240,  0, 32'h200, 1, 1, 32'h240));
    vecs.push_back(mk("sat_t3",     1, 32'h200, 1, 32'h240,  0, 32'h200, 1, 1, 32'h240));
    vecs.push_back(mk("sat_t4",     1, 32'h200, 1, 32'h244,  0, 32'h200, 1, 1, 32'h240));
    vecs.push_back(mk("sat_nt1",    1, 32'h200, 0, 32'hDEAD, 0, 32'h200, 1, 1, 32'h244));
    vecs.push_back(mk("ctr10",      0, 32'h0,   0, 32'h0,    0, 32'h200, 1, 1, 32'h244));
    vecs.push_back(mk("sat_nt2",    1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 1, 32'h244));
    vecs.push_back(mk("sat_nt3",    1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 0, 32'h0));
    vecs.push_back(mk("sat_nt4",    1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 0, 32'h0));
    vecs.push_back(mk("sat_nt5",    1, 32'h200, 0, 32'h0,    0, 32'h200, 1, 0, 32'h0));
    vecs.push_back(mk("from00_t",   1, 32'h200, 1, 32'h248,  0, 32'h200, 1, 0, 32'h0));
    vecs.push_back(mk("ctr01",      1, 32'h200, 1, 32'h248,  0, 32'h200, 1, 0, 32'h0));
    vecs.push_back(mk("ctr10b",     0, 32'h0,   0, 32'h0,    0, 32'h200, 1, 1, 32'h248));
    vecs.push_back(mk("alias_a",    1, 32'h100, 1, 32'h80,   0, 32'h100, 0, 0, 32'h0));
    vecs.push_back(mk("alias_b",    1, 32'h500, 0, 32'h0,    0, 32'h100, 1, 1, 32'h80));
    vecs.push_back(mk("alias_old",  0, 32'h0,   0, 32'h0,    0, 32'h100, 0, 0, 32'h0));
    vecs.push_back(mk("alias_new",  0, 32'h0,   0, 32'h0,    0, 32'h500, 1, 0, 32'h0));
    vecs.push_back(mk("noupd",      0, 32'h500, 1, 32'h999,  0, 32'h500, 1, 0, 32'h0));
    vecs.push_back(mk("noupd_chk",  0, 32'h0,   0, 32'h0,    0, 32'h500, 1, 0, 32'h0));
    vecs.push_back(mk("idx1_alloc", 1, 32'h104, 1, 32'h1000, 0, 32'h104, 0, 0, 32'h0));
    vecs.push_back(mk("idx1_lowbit",0, 32'h0,   0, 32'h0,    0, 32'h107, 1, 1, 32'h1000));
    vecs.push_back(mk("idx0_keep",  0, 32'h0,   0, 32'h0,    0, 32'h500, 1, 0, 32'h0));

    foreach (vecs[i]) step(vecs[i]);

    // Same-cycle lookup and update: lookup sees pre-update state.
    step(mk("same_alloc",   1, 32'h300, 0, 32'h0,    0, 32'h300, 0, 0, 32'h0));
    step(mk("same_cycle",   1, 32'h300, 1, 32'h340,  0, 32'h300, 1, 0, 32'h0));
    step(mk("same_next",    0, 32'h0,   0, 32'h0,    0, 32'h300, 1, 1, 32'h340));
    // Flush with a simultaneous update: update dropped, everything invalid.
    step(mk("flush_upd",    1, 32'h104, 1, 32'h2000, 1, 32'h300, 1, 1, 32'h340));
    step(mk("flush_300",    0, 32'h0,   0, 32'h0,    0, 32'h300, 0, 0, 32'h0));
    step(mk("flush_104",    0, 32'h0,   0, 32'h0,    0, 32'h104, 0, 0, 32'h0));
    step(mk("flush_500",    0, 32'h0,   0, 32'h0,    0, 32'h500, 0, 0, 32'h0));
`ifdef OTTER_BP_PERF_EN
    chk("perf_upd_after_flush", o_perf_updates,     model_upd);
    chk("perf_mis_after_flush", o_perf_mispredicts, model_mis);
`endif

    // Asynchronous reset in the middle of operation.
    step(mk("pre_rst_t",    1, 32'h300, 1, 32'h380,  0, 32'h300, 0, 0, 32'h0));
    step(mk("pre_rst_chk",  0, 32'h0,   0, 32'h0,    0, 32'h300, 1, 1, 32'h380));
    #1; i_rst_n = 1'b0;
    #1;
    chk("midrst_hit",    {31'd0, o_pred_hit},   32'd0);
    chk("midrst_taken",  {31'd0, o_pred_taken}, 32'd0);
    chk("midrst_target", o_pred_target,         32'd0);
    @(posedge clk); #1; i_rst_n = 1'b1;
`ifdef OTTER_BP_PERF_EN
    model_upd = 0;
    model_mis = 0;
`endif
    step(mk("post_rst_nt",  1, 32'h300, 0, 32'h0,    0, 32'h300, 0, 0, 32'h0));
    step(mk("post_rst_chk", 0, 32'h0,   0, 32'h0,    0, 32'h300, 1, 0, 32'h0));

`ifdef OTTER_BP_PERF_EN
    // Fresh reset, then five updates with two mispredictions.
    @(negedge clk); #1; i_rst_n = 1'b0;
    @(posedge clk); #1; i_rst_n = 1'b1;
    model_upd = 0;
    model_mis = 0;
    v = mk("perf1", 1, 32'h400, 1, 32'h40, 0, 32'h400, 0, 0, 32'h0); v.upred = 1; step(v);
    v = mk("perf2", 1, 32'h400, 1, 32'h40, 0, 32'h400, 1, 1, 32'h40); v.upred = 0; step(v);
    v = mk("perf3", 1, 32'h400, 0, 32'h0,  0, 32'h400, 1, 1, 32'h40); v.upred = 1; step(v);
    v = mk("perf4", 1, 32'h400, 0, 32'h0,  0, 32'h400, 1, 1, 32'h40); v.upred = 0; step(v);
    v = mk("perf5", 1, 32'h404, 1, 32'h80, 0, 32'h400, 1, 0, 32'h0);  v.upred = 1; step(v);
    step(mk("perf_idle", 0, 32'h0, 0, 32'h0, 0, 32'h404, 1, 1, 32'h80));
    chk("perf_updates",     o_perf_updates,     32'd5);
    chk("perf_mispredicts", o_perf_mispredicts, 32'd2);
    #1; i_rst_n = 1'b0;
    #1;
    chk("perf_rst_upd", o_perf_updates,     32'd0);
    chk("perf_rst_mis", o_perf_mispredicts, 32'd0);
    @(posedge clk); #1; i_rst_n = 1'b1;
`else
    v = mk("tail", 0, 32'h0, 0, 32'h0, 0, 32'h300, 1, 0, 32'h0);
    step(v);
`endif

    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
